// File: rtl/pingpang_feeder.sv
// pingpang_feeder: drains one ping-pong FIFO bank per tile into a 4-lane PE array.
// Waits for the awaited bank to be full, bursts DEPTH reads, and feeds each returned word
// through a 1-entry skid and an output stage that stalls with pe_ready.
// Ports: clk, rst (sync, active-high), fifo_state[3:0] {b1 empty, b0 empty, b1 full, b0 full},
//        rd, r_data (valid 1 cycle after rd), pe_ready, pe_data, pe_valid[3:0],
//        tile_done (1-cycle pulse), busy (FSM not idle), cur_bank.
// Optional macro FEEDER_SKEW_EN: lane k is delayed k extra pipe advances (systolic skew).

module pingpang_feeder #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          fifo_state,
    output logic                rd,
    input  logic [4*DWIDTH-1:0] r_data,
    input  logic                pe_ready,
    output logic [4*DWIDTH-1:0] pe_data,
    output logic [3:0]          pe_valid,
    output logic                tile_done,
    output logic                busy,
    output logic                cur_bank
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       rd_cnt;
    logic                inflight;
    logic                skid_full;
    logic [4*DWIDTH-1:0] skid;
    logic [4*DWIDTH-1:0] s0_data;
    logic                s0_vld;
    logic [4*DWIDTH-1:0] in_data;
    logic                in_vld;
    logic                pipe_busy;

    // Empty-status bits are informational only.
    logic unused_empty;
    assign unused_empty = ^fifo_state[3:2];

    // Reads stop while skid holds a word, so skid and returning data never coexist.
    // Reset masks rd immediately so an aborted burst issues nothing in the reset cycle.
    assign rd = (state == BURST) & pe_ready & ~skid_full
              & (rd_cnt < CW'(DEPTH)) & ~rst;

    // Skid has priority over returning data; both cannot be valid together.
    assign in_data = skid_full ? skid : r_data;
    assign in_vld  = skid_full | inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= 1'b0;
            skid_full <= 1'b0;
            skid      <= '0;
        end else begin
            inflight <= rd;
            if (pe_ready) begin
                skid_full <= 1'b0;
            end else if (inflight) begin
                skid_full <= 1'b1;
                skid      <= r_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_data <= '0;
            s0_vld  <= 1'b0;
        end else if (pe_ready) begin
            s0_vld <= in_vld;
            if (in_vld) begin
                s0_data <= in_data;
            end
        end
    end

`ifdef FEEDER_SKEW_EN
    // Lane k taps the end of a k-deep chain behind stage 0.
    logic [DWIDTH-1:0]      l1_d;
    logic                   l1_v;
    logic [1:0][DWIDTH-1:0] l2_d;
    logic [1:0]             l2_v;
    logic [2:0][DWIDTH-1:0] l3_d;
    logic [2:0]             l3_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            l1_d <= '0;
            l1_v <= 1'b0;
            l2_d <= '0;
            l2_v <= '0;
            l3_d <= '0;
            l3_v <= '0;
        end else if (pe_ready) begin
            l1_d <= s0_data[DWIDTH +: DWIDTH];
            l1_v <= s0_vld;
            l2_d <= {l2_d[0], s0_data[2*DWIDTH +: DWIDTH]};
            l2_v <= {l2_v[0], s0_vld};
            l3_d <= {l3_d[1:0], s0_data[3*DWIDTH +: DWIDTH]};
            l3_v <= {l3_v[1:0], s0_vld};
        end
    end

    assign pe_data   = {l3_d[2], l2_d[1], l1_d, s0_data[DWIDTH-1:0]};
    assign pe_valid  = {l3_v[2], l2_v[1], l1_v, s0_vld};
    assign pipe_busy = s0_vld | l1_v | (|l2_v) | (|l3_v);
`else
    assign pe_data   = s0_data;
    assign pe_valid  = {4{s0_vld}};
    assign pipe_busy = s0_vld;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            cur_bank  <= 1'b0;
            busy      <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_state[{1'b0, cur_bank}]) begin
                        state  <= BURST;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                BURST: begin
                    if (rd) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == CW'(DEPTH - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight && !skid_full && !pipe_busy) begin
                        state     <= DONE;
                        tile_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cur_bank <= ~cur_bank;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pingpang_feeder.sv
// tb_pingpang_feeder: directed bench for pingpang_feeder with a 1-cycle-latency FIFO model.
// Checks latency, per-lane delivered streams, bank alternation, backpressure and abort.

module tb_pingpang_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  fifo_state = 4'b0;
    logic        rd;
    logic [31:0] r_data = 32'h0;
    logic        pe_ready = 1'b1;
    logic [31:0] pe_data;
    logic [3:0]  pe_valid;
    logic        tile_done;
    logic        busy;
    logic        cur_bank;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] fq[$];
    logic [7:0]  lane_q[4][$];
    int          viol = 0;
    int          rd_seen = 0;
    int          pv_bad = 0;
    logic        m_infl = 1'b0;
    logic        m_skid = 1'b0;
    logic        skid_used = 1'b0;

    pingpang_feeder #(.DWIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_state(fifo_state),
        .rd        (rd),
        .r_data    (r_data),
        .pe_ready  (pe_ready),
        .pe_data   (pe_data),
        .pe_valid  (pe_valid),
        .tile_done (tile_done),
        .busy      (busy),
        .cur_bank  (cur_bank)
    );

    always #5 clk = ~clk;

    // FIFO model: data returns the cycle after rd. Also an independent skid-occupancy model.
    always @(posedge clk) begin
        if (rd) begin
            if (fq.size() > 0) r_data <= fq.pop_front();
            else               r_data <= 32'hDEADBEEF;
        end
        if (rst) begin
            m_infl <= 1'b0;
            m_skid <= 1'b0;
        end else begin
            m_infl <= rd;
            if (pe_ready) m_skid <= 1'b0;
            else if (m_infl) begin
                m_skid    <= 1'b1;
                skid_used <= 1'b1;
            end
        end
    end

    // Delivered-lane collector and protocol observers.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++)
                if (pe_valid[k] && pe_ready) lane_q[k].push_back(pe_data[k*8 +: 8]);
            if (rd) rd_seen++;
            if (rd && (!pe_ready || m_skid)) viol++;
`ifndef FEEDER_SKEW_EN
            if (pe_valid != 4'h0 && pe_valid != 4'hF) pv_bad++;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input int i);
        return 32'h03020100 + 32'(4 * i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        for (int k = 0; k < 4; k++) lane_q[k].delete();
        fq.delete();
        viol = 0;
        rd_seen = 0;
        pv_bad = 0;
        skid_used = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        fifo_state = 4'b0;
        pe_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear();
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(word(base + i));
    endtask

    task automatic chk_stream(input string tag, input int n);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_len_l%0d", tag, k), 32'(lane_q[k].size()), 32'(n));
            for (int i = 0; i < n && i < lane_q[k].size(); i++) begin
                w = word(i);
                chk($sformatf("%s_l%0d_w%0d", tag, k, i),
                    32'(lane_q[k][i]), 32'(w[k*8 +: 8]));
            end
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        @(negedge clk);
        while (!tile_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(tile_done), 32'd1);
    endtask

    logic       exp_rd [13] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef FEEDER_SKEW_EN
    logic [3:0] exp_pv [13] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF,
                                4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0};
    logic       exp_td [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`else
    logic [3:0] exp_pv [13] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       exp_td [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
`endif

    initial begin
        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_pe_data", pe_data, 32'd0);
        chk("rst_pe_valid", 32'(pe_valid), 32'd0);
        chk("rst_tile_done", 32'(tile_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_bank", 32'(cur_bank), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear();

        // Other bank full while awaiting bank0: no activity
        fifo_state = 4'b0010;
        load(0, 4);
        repeat (6) @(negedge clk);
        chk("wait_rd_cnt", 32'(rd_seen), 32'd0);
        chk("wait_busy", 32'(busy), 32'd0);

        // Single tile, pe_ready held high: cycle-exact trace
        do_reset();
        load(0, 4);
        fifo_state = 4'b0001;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("t1_rd_n%0d", i), 32'(rd), 32'(exp_rd[i]));
            chk($sformatf("t1_pv_n%0d", i), 32'(pe_valid), 32'(exp_pv[i]));
            chk($sformatf("t1_td_n%0d", i), 32'(tile_done), 32'(exp_td[i]));
            if (i == 1) chk("t1_busy", 32'(busy), 32'd1);
            if (i == 3) chk("t1_lane0_first", 32'(pe_data[7:0]), 32'h00);
            if (exp_td[i]) chk("t1_bank_in_done", 32'(cur_bank), 32'd0);
        end
        chk("t1_cur_bank", 32'(cur_bank), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_rd_total", 32'(rd_seen), 32'd4);
        chk("t1_pv_shape", 32'(pv_bad), 32'd0);
        chk_stream("t1", 4);

        // Bank alternation: two tiles back to back
        do_reset();
        load(0, 8);
        fifo_state = 4'b0011;
        wait_done("alt_done0", 40);
        chk("alt_bank_t0", 32'(cur_bank), 32'd0);
        wait_done("alt_done1", 40);
        chk("alt_bank_t1", 32'(cur_bank), 32'd1);
        @(posedge clk); #1;
        fifo_state = 4'b0000;
        @(negedge clk);
        chk("alt_bank_end", 32'(cur_bank), 32'd0);
        repeat (4) @(negedge clk);
        chk("alt_busy_end", 32'(busy), 32'd0);
        chk("alt_rd_total", 32'(rd_seen), 32'd8);
        chk_stream("alt", 8);

        // Backpressure: pe_ready toggles every cycle
        do_reset();
        load(0, 4);
        fifo_state = 4'b0001;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            pe_ready = ~pe_ready;
            @(negedge clk);
            if (tile_done) break;
        end
        chk("bp_done", 32'(tile_done), 32'd1);
        chk("bp_skid_used", 32'(skid_used), 32'd1);
        chk("bp_rd_viol", 32'(viol), 32'd0);
        chk("bp_rd_total", 32'(rd_seen), 32'd4);
        chk("bp_pv_shape", 32'(pv_bad), 32'd0);
        chk_stream("bp", 4);
        @(posedge clk); #1;
        pe_ready = 1'b1;

        // Reset in the cycle after the second rd
        do_reset();
        load(0, 4);
        fifo_state = 4'b0001;
        @(negedge clk);
        chk("ab_rd_n0", 32'(rd), 32'd0);
        @(negedge clk);
        chk("ab_rd_n1", 32'(rd), 32'd1);
        @(negedge clk);
        chk("ab_rd_n2", 32'(rd), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        fifo_state = 4'b0000;
        @(negedge clk);
        chk("ab_rd_in_rst", 32'(rd), 32'd0);
        @(negedge clk);
        chk("ab_pe_data", pe_data, 32'd0);
        chk("ab_pe_valid", 32'(pe_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_tile_done", 32'(tile_done), 32'd0);
        chk("ab_cur_bank", 32'(cur_bank), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("ab_rd_total", 32'(rd_seen), 32'd2);
        chk("ab_fifo_left", 32'(fq.size()), 32'd2);
        chk("ab_busy_after", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
